// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request bundle for the two register-file writers.
// master = requesters, slave = arbiter.
interface regfile_wb_arbiter_if;
    logic        r0_valid;
    logic [4:0]  r0_addr;
    logic [31:0] r0_data;
    logic        r0_ready;
    logic        r1_valid;
    logic [4:0]  r1_addr;
    logic [31:0] r1_data;
    logic        r1_ready;

    modport master (
        output r0_valid, r0_addr, r0_data,
        output r1_valid, r1_addr, r1_data,
        input  r0_ready, r1_ready
    );

    modport slave (
        input  r0_valid, r0_addr, r0_data,
        input  r1_valid, r1_addr, r1_data,
        output r0_ready, r1_ready
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Two-way writeback arbiter with anti-starvation and registered RF write port.
// Optional pending-write scoreboard enabled by macro RF_SCOREBOARD_EN.
module regfile_wb_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 resetn,
    regfile_wb_arbiter_if.slave  bus,
    output logic                 rf_we,
    output logic [4:0]           rf_waddr,
    output logic [31:0]          rf_wdata,
    input  logic                 sb_set,
    input  logic [4:0]           sb_addr,
    input  logic [4:0]           chk_addr1,
    input  logic [4:0]           chk_addr2,
    output logic                 hazard,
    output logic [31:0]          busy_vec
);

    localparam int CW = $clog2(STARVE_LIMIT + 2);
    localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

    logic [CW-1:0] starve_q, starve_d;
    logic          rf_we_q;
    logic [4:0]    rf_waddr_q;
    logic [31:0]   rf_wdata_q;

    logic          g0, g1, xfer;
    logic [4:0]    w_addr;
    logic [31:0]   w_data;

    // r1 wins only when r0 is idle or r1 has been refused long enough
    assign g1 = bus.r1_valid & (~bus.r0_valid | (starve_q == LIM));
    assign g0 = bus.r0_valid & ~g1;

    assign bus.r0_ready = resetn & g0;
    assign bus.r1_ready = resetn & g1;

    assign xfer   = g0 | g1;
    assign w_addr = g1 ? bus.r1_addr : bus.r0_addr;
    assign w_data = g1 ? bus.r1_data : bus.r0_data;

    always_comb begin
        starve_d = '0;
        if (bus.r1_valid && !g1) begin
            starve_d = (starve_q == LIM) ? LIM : starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            starve_q   <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            starve_q <= starve_d;
            rf_we_q  <= xfer && (w_addr != 5'd0);
            if (xfer) begin
                rf_waddr_q <= w_addr;
                rf_wdata_q <= w_data;
            end
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;

`ifdef RF_SCOREBOARD_EN
    logic [31:0] busy_q, busy_d;

    // set is applied after clear so a same-edge set/clear leaves the bit set
    always_comb begin
        busy_d = busy_q;
        if (xfer) begin
            busy_d[w_addr] = 1'b0;
        end
        if (sb_set) begin
            busy_d[sb_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;
    assign hazard   = resetn & (busy_q[chk_addr1] | busy_q[chk_addr2]);
`else
    logic unused_sb;
    assign unused_sb = ^{sb_set, sb_addr, chk_addr1, chk_addr2};
    assign busy_vec  = '0;
    assign hazard    = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized self-checking bench for regfile_wb_arbiter.
// Scoreboard checks follow RF_SCOREBOARD_EN.
module tb_regfile_wb_arbiter;

    localparam int LIM = 4;

    logic        clk;
    logic        resetn;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        sb_set;
    logic [4:0]  sb_addr;
    logic [4:0]  chk_addr1;
    logic [4:0]  chk_addr2;
    logic        hazard;
    logic [31:0] busy_vec;

    regfile_wb_arbiter_if bus ();

    regfile_wb_arbiter #(.STARVE_LIMIT(LIM)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .bus       (bus),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .sb_set    (sb_set),
        .sb_addr   (sb_addr),
        .chk_addr1 (chk_addr1),
        .chk_addr2 (chk_addr2),
        .hazard    (hazard),
        .busy_vec  (busy_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // reference model state
    int          m_starve;
    bit [31:0]   m_busy;
    bit          exp_we;
    bit [4:0]    exp_waddr;
    bit [31:0]   exp_wdata;

    task automatic model_reset();
        m_starve  = 0;
        m_busy    = '0;
        exp_we    = 1'b0;
        exp_waddr = '0;
        exp_wdata = '0;
    endtask

    task automatic model_grant(output bit g0, output bit g1);
        g1 = bus.r1_valid && (!bus.r0_valid || m_starve >= LIM);
        g0 = bus.r0_valid && !g1;
    endtask

    function automatic bit model_hazard();
`ifdef RF_SCOREBOARD_EN
        return m_busy[chk_addr1] | m_busy[chk_addr2];
`else
        return 1'b0;
`endif
    endfunction

    // advance model across one edge, then wait past that edge
    task automatic tick();
        bit g0, g1;
        bit [4:0] a;
        bit [31:0] d;
        model_grant(g0, g1);
        a = g1 ? bus.r1_addr : bus.r0_addr;
        d = g1 ? bus.r1_data : bus.r0_data;
        exp_we = (g0 || g1) && (a != 0);
        if (g0 || g1) begin
            exp_waddr = a;
            exp_wdata = d;
        end
        if (bus.r1_valid && !g1)
            m_starve = (m_starve + 1 > LIM) ? LIM : m_starve + 1;
        else
            m_starve = 0;
`ifdef RF_SCOREBOARD_EN
        if (g0 || g1) m_busy[a] = 1'b0;
        if (sb_set && sb_addr != 0) m_busy[sb_addr] = 1'b1;
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v0, input bit [4:0] a0, input bit [31:0] d0,
                         input bit v1, input bit [4:0] a1, input bit [31:0] d1,
                         input bit s, input bit [4:0] sa,
                         input bit [4:0] c1, input bit [4:0] c2);
        @(negedge clk);
        bus.r0_valid = v0; bus.r0_addr = a0; bus.r0_data = d0;
        bus.r1_valid = v1; bus.r1_addr = a1; bus.r1_data = d1;
        sb_set = s; sb_addr = sa;
        chk_addr1 = c1; chk_addr2 = c2;
        #1;
    endtask

    task automatic test_reset();
        bus.r0_valid = 1; bus.r0_addr = 5'd3; bus.r0_data = 32'h1;
        bus.r1_valid = 1; bus.r1_addr = 5'd4; bus.r1_data = 32'h2;
        sb_set = 1; sb_addr = 5'd6; chk_addr1 = 5'd6; chk_addr2 = 5'd0;
        #3;
        n_total++;
        if (bus.r0_ready !== 1'b0 || bus.r1_ready !== 1'b0)
            $display("FAIL reset_ready got %b%b want 00", bus.r0_ready, bus.r1_ready);
        else n_pass++;
        n_total++;
        if ({rf_we, rf_waddr, rf_wdata} !== 38'd0)
            $display("FAIL reset_wport got we=%b a=%0d d=%h want 0", rf_we, rf_waddr, rf_wdata);
        else n_pass++;
        @(posedge clk); @(posedge clk); #1;
        n_total++;
        if (rf_we !== 1'b0 || busy_vec !== 32'd0 || hazard !== 1'b0)
            $display("FAIL reset_hold got we=%b busy=%h hz=%b want 0", rf_we, busy_vec, hazard);
        else n_pass++;
        @(negedge clk);
        bus.r0_valid = 0; bus.r1_valid = 0; sb_set = 0;
        resetn = 1;
        model_reset();
    endtask

    task automatic test_single();
        drive(1, 5'd5, 32'h1234, 0, 5'd0, 32'h0, 0, 5'd0, 5'd0, 5'd0);
        n_total++;
        if (bus.r0_ready !== 1'b1 || bus.r1_ready !== 1'b0)
            $display("FAIL single_ready got %b%b want 10", bus.r0_ready, bus.r1_ready);
        else n_pass++;
        tick();
        n_total++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'h1234)
            $display("FAIL single_wport got we=%b a=%0d d=%h want 1/5/1234", rf_we, rf_waddr, rf_wdata);
        else n_pass++;
        drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0, 5'd0, 5'd0);
        tick();
        n_total++;
        if (rf_we !== 1'b0)
            $display("FAIL idle_we got %b want 0", rf_we);
        else n_pass++;
    endtask

    task automatic test_starve();
        bit want1;
        for (int i = 0; i < 7; i++) begin
            drive(1, 5'd3, 32'h100 + i, 1, 5'd7, 32'hA7, 0, 5'd0, 5'd0, 5'd0);
            want1 = (i == LIM);
            n_total++;
            if (bus.r1_ready !== want1 || bus.r0_ready !== !want1)
                $display("FAIL starve_grant cyc%0d got r0=%b r1=%b want r1=%b", i, bus.r0_ready, bus.r1_ready, want1);
            else n_pass++;
            tick();
            n_total++;
            if (rf_we !== 1'b1 || rf_waddr !== (want1 ? 5'd7 : 5'd3))
                $display("FAIL starve_wport cyc%0d got we=%b a=%0d want a=%0d", i, rf_we, rf_waddr, want1 ? 7 : 3);
            else n_pass++;
        end
        drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0, 5'd0, 5'd0);
        tick();
    endtask

    task automatic test_addr0();
        drive(0, 5'd0, 32'h0, 1, 5'd0, 32'hFFFFFFFF, 0, 5'd0, 5'd0, 5'd0);
        n_total++;
        if (bus.r1_ready !== 1'b1)
            $display("FAIL addr0_ready got %b want 1", bus.r1_ready);
        else n_pass++;
        tick();
        n_total++;
        if (rf_we !== 1'b0)
            $display("FAIL addr0_we got %b want 0", rf_we);
        else n_pass++;
    endtask

    task automatic test_scoreboard();
`ifdef RF_SCOREBOARD_EN
        drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 5'd9, 5'd9, 5'd0);
        tick();
        drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0, 5'd9, 5'd0);
        n_total++;
        if (hazard !== 1'b1 || busy_vec !== 32'h200)
            $display("FAIL sb_set got hz=%b busy=%h want 1/00000200", hazard, busy_vec);
        else n_pass++;
        drive(0, 5'd0, 32'h0, 1, 5'd9, 32'h99, 0, 5'd0, 5'd9, 5'd0);
        tick();
        n_total++;
        if (rf_we !== 1'b1 || busy_vec !== 32'h0)
            $display("FAIL sb_clear got we=%b busy=%h want 1/0", rf_we, busy_vec);
        else n_pass++;
        drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 5'd9, 5'd9, 5'd0);
        tick();
        drive(1, 5'd9, 32'h9, 0, 5'd0, 32'h0, 1, 5'd9, 5'd0, 5'd9);
        tick();
        drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0, 5'd9, 5'd0);
        n_total++;
        if (hazard !== 1'b1 || busy_vec !== 32'h200)
            $display("FAIL sb_same_edge got hz=%b busy=%h want 1/00000200", hazard, busy_vec);
        else n_pass++;
        drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 5'd0, 5'd0, 5'd0);
        tick();
        n_total++;
        if (busy_vec[0] !== 1'b0 || busy_vec !== m_busy)
            $display("FAIL sb_addr0 got busy=%h want %h", busy_vec, m_busy);
        else n_pass++;
`else
        drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 5'd9, 5'd9, 5'd9);
        tick();
        n_total++;
        if (hazard !== 1'b0 || busy_vec !== 32'h0)
            $display("FAIL sb_tied got hz=%b busy=%h want 0/0", hazard, busy_vec);
        else n_pass++;
`endif
    endtask

    task automatic test_random();
        bit g0, g1;
        int errs;
        errs = 0;
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 99) < 70, 5'($urandom_range(0, 15)), $urandom,
                  $urandom_range(0, 99) < 60, 5'($urandom_range(0, 15)), $urandom,
                  $urandom_range(0, 99) < 30, 5'($urandom_range(0, 15)),
                  5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)));
            model_grant(g0, g1);
            n_total++;
            if (bus.r0_ready !== g0 || bus.r1_ready !== g1 || hazard !== model_hazard()) begin
                if (errs < 10)
                    $display("FAIL rand_comb cyc%0d got r0=%b r1=%b hz=%b want %b %b %b",
                             i, bus.r0_ready, bus.r1_ready, hazard, g0, g1, model_hazard());
                errs++;
            end else n_pass++;
            tick();
            n_total++;
            if (rf_we !== exp_we || busy_vec !== m_busy ||
                (exp_we && (rf_waddr !== exp_waddr || rf_wdata !== exp_wdata))) begin
                if (errs < 10)
                    $display("FAIL rand_seq cyc%0d got we=%b a=%0d d=%h busy=%h want %b %0d %h %h",
                             i, rf_we, rf_waddr, rf_wdata, busy_vec, exp_we, exp_waddr, exp_wdata, m_busy);
                errs++;
            end else n_pass++;
        end
        drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0, 5'd0, 5'd0);
        tick();
    endtask

    task automatic test_async_reset();
        drive(1, 5'd3, 32'hCAFE, 0, 5'd0, 32'h0, 1, 5'd9, 5'd0, 5'd0);
        tick();
        n_total++;
        if (rf_we !== 1'b1 || busy_vec !== m_busy)
            $display("FAIL pre_reset got we=%b busy=%h want 1/%h", rf_we, busy_vec, m_busy);
        else n_pass++;
        bus.r1_valid = 1;
        #1 resetn = 0;
        #1;
        n_total++;
        if (rf_we !== 1'b0 || busy_vec !== 32'h0 || rf_waddr !== 5'd0 || rf_wdata !== 32'h0)
            $display("FAIL async_reset got we=%b a=%0d d=%h busy=%h want 0", rf_we, rf_waddr, rf_wdata, busy_vec);
        else n_pass++;
        n_total++;
        if (bus.r0_ready !== 1'b0 || bus.r1_ready !== 1'b0 || hazard !== 1'b0)
            $display("FAIL async_ready got %b%b hz=%b want 000", bus.r0_ready, bus.r1_ready, hazard);
        else n_pass++;
        @(posedge clk); #1;
        n_total++;
        if (rf_we !== 1'b0 || bus.r0_ready !== 1'b0)
            $display("FAIL reset_held got we=%b r0=%b want 0", rf_we, bus.r0_ready);
        else n_pass++;
        @(negedge clk);
        resetn = 1;
        model_reset();
        drive(1, 5'd12, 32'h55, 1, 5'd13, 32'h66, 0, 5'd0, 5'd0, 5'd0);
        n_total++;
        if (bus.r0_ready !== 1'b1 || bus.r1_ready !== 1'b0)
            $display("FAIL post_reset_grant got %b%b want 10", bus.r0_ready, bus.r1_ready);
        else n_pass++;
        tick();
        n_total++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd12 || rf_wdata !== 32'h55)
            $display("FAIL post_reset_wport got we=%b a=%0d d=%h want 1/12/55", rf_we, rf_waddr, rf_wdata);
        else n_pass++;
    endtask

    initial begin
        resetn = 0;
        model_reset();
        test_reset();
        test_single();
        test_starve();
        test_addr0();
        test_scoreboard();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
